// File: rtl/flags_cond_unit.sv
// Condition-flag register (NZCV) with same-cycle forwarding into an ARM
// condition evaluator, a one-entry response register with valid/ready
// handshake, and a saturating counter of taken conditions.
module flags_cond_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_wr_valid,
    input  logic [3:0]  flag_wr_mask,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        msr_valid,
    input  logic [3:0]  msr_data,
    input  logic        cond_req_valid,
    input  logic [3:0]  cond_code,
    output logic        cond_req_ready,
    output logic        cond_resp_valid,
    output logic        cond_taken,
    output logic        cond_undef,
    input  logic        cond_resp_ready,
    output logic [3:0]  apsr_nzcv,
    output logic        carry_to_alu,
    output logic [15:0] taken_count
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} resp_state_t;

    resp_state_t state, state_nxt;
    logic [3:0]  apsr_q;
    logic [3:0]  alu_nzcv;
    logic [3:0]  fwd_nzcv;
    logic        fn, fz, fc, fv;
    logic        eval_taken, eval_undef;
    logic        req_accept;
    logic        taken_q, undef_q;
    logic [15:0] cnt_q;

    assign alu_nzcv = {alu_negative, alu_zero, alu_carry, alu_overflow};

    // Forwarded flags: the value apsr will hold after this cycle's write.
    // MSR wins outright; an ALU write only touches its masked bits.
    always_comb begin
        fwd_nzcv = apsr_q;
        if (msr_valid)
            fwd_nzcv = msr_data;
        else if (flag_wr_valid)
            fwd_nzcv = (apsr_q & ~flag_wr_mask) | (alu_nzcv & flag_wr_mask);
    end

    assign {fn, fz, fc, fv} = fwd_nzcv;

    // ARM condition decode against the forwarded flags.
    always_comb begin
        eval_taken = 1'b0;
        eval_undef = 1'b0;
        case (cond_code)
            4'd0:  eval_taken = fz;
            4'd1:  eval_taken = !fz;
            4'd2:  eval_taken = fc;
            4'd3:  eval_taken = !fc;
            4'd4:  eval_taken = fn;
            4'd5:  eval_taken = !fn;
            4'd6:  eval_taken = fv;
            4'd7:  eval_taken = !fv;
            4'd8:  eval_taken = fc && !fz;
            4'd9:  eval_taken = !fc || fz;
            4'd10: eval_taken = (fn == fv);
            4'd11: eval_taken = (fn != fv);
            4'd12: eval_taken = !fz && (fn == fv);
            4'd13: eval_taken = fz || (fn != fv);
            4'd14: eval_taken = 1'b1;
            default: begin
                eval_taken = 1'b0;
                eval_undef = 1'b1;
            end
        endcase
    end

    // Ready whenever the output slot is empty or draining this cycle; reads
    // as empty during reset, but nothing is accepted while rst_n is low.
    assign cond_req_ready = !rst_n || (state == S_EMPTY) || cond_resp_ready;
    assign req_accept     = rst_n && cond_req_valid && cond_req_ready;

    // Response slot next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (req_accept) state_nxt = S_FULL;
            S_FULL: begin
                if (req_accept)           state_nxt = S_FULL;
                else if (cond_resp_ready) state_nxt = S_EMPTY;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Response slot state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // Response payload: loaded only on accept, so a held result never
    // tracks later flag changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q <= 1'b0;
            undef_q <= 1'b0;
        end else if (req_accept) begin
            taken_q <= eval_taken;
            undef_q <= eval_undef;
        end
    end

    // Architectural flag register commits the forwarded value.
    always_ff @(posedge clk) begin
        if (!rst_n) apsr_q <= 4'b0000;
        else        apsr_q <= fwd_nzcv;
    end

    // Saturating taken counter; undefined codes never evaluate taken.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= 16'h0000;
        else if (req_accept && eval_taken && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign cond_resp_valid = (state == S_FULL);
    assign cond_taken      = taken_q;
    assign cond_undef      = undef_q;
    assign apsr_nzcv       = apsr_q;
    assign carry_to_alu    = apsr_q[1];
    assign taken_count     = cnt_q;

endmodule
